signed_div_sequencer: RTL and testbench

// Upstream/downstream wrapper for the unsigned long-division core. Accepts signed

---
 rtl/signed_div_sequencer_if.sv | 37 +++
 rtl/signed_div_sequencer.sv | 141 ++++++++++++++
 tb/tb_signed_div_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/signed_div_sequencer_if.sv
// Request, core and result signals of the signed divide sequencer.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface signed_div_sequencer_if #(
    parameter int unsigned WIDTH = 12
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_num;
    logic [WIDTH-1:0] s_den;

    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic             div_valid;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic             div_ready;

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_quot;
    logic [WIDTH-1:0] m_rem;
    logic             m_err_div0;
    logic             m_ovf;
    logic             m_timeout;

    modport slave (
        input  s_valid, s_num, s_den, div_quot, div_rem, div_ready, m_ready,
        output s_ready, div_num, div_den, div_valid,
        output m_valid, m_quot, m_rem, m_err_div0, m_ovf, m_timeout
    );

    modport master (
        output s_valid, s_num, s_den, div_quot, div_rem, div_ready, m_ready,
        input  s_ready, div_num, div_den, div_valid,
        input  m_valid, m_quot, m_rem, m_err_div0, m_ovf, m_timeout
    );
endinterface

// File: rtl/signed_div_sequencer.sv
// Signed front end for an unsigned long-division core: strips signs, starts the core,
// waits (bounded) for its answer, restores signs and holds the result until accepted.
module signed_div_sequencer #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned TIMEOUT = 64
) (
    input logic                  aclk,
    input logic                  resetn,
    signed_div_sequencer_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    // Leaving WAIT on this count puts the timeout result TIMEOUT cycles after div_valid.
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 2);
    localparam logic [WIDTH-1:0] QuotMax = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e           state_q;
    logic             s_ready_q;
    logic             div_valid_q;
    logic [WIDTH-1:0] div_num_q;
    logic [WIDTH-1:0] div_den_q;
    logic             sign_n_q;
    logic             sign_d_q;
    logic [TW-1:0]    timer_q;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_quot_q;
    logic [WIDTH-1:0] m_rem_q;
    logic             m_err_div0_q;
    logic             m_ovf_q;
    logic             m_timeout_q;

    logic             neg_quot;
    logic             ovf_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    // -2^(W-1) maps to 2^(W-1), which still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        m = x[WIDTH-1] ? (~x + 1'b1) : x;
        return m;
    endfunction

    always_comb begin
        neg_quot = sign_n_q ^ sign_d_q;
        ovf_fix  = !neg_quot && bus.div_quot[WIDTH-1];
        quot_fix = neg_quot ? (~bus.div_quot + 1'b1) : bus.div_quot;
        if (ovf_fix) begin
            quot_fix = QuotMax;
        end
        rem_fix = sign_n_q ? (~bus.div_rem + 1'b1) : bus.div_rem;
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            s_ready_q    <= 1'b1;
            div_valid_q  <= 1'b0;
            div_num_q    <= '0;
            div_den_q    <= '0;
            sign_n_q     <= 1'b0;
            sign_d_q     <= 1'b0;
            timer_q      <= '0;
            m_valid_q    <= 1'b0;
            m_quot_q     <= '0;
            m_rem_q      <= '0;
            m_err_div0_q <= 1'b0;
            m_ovf_q      <= 1'b0;
            m_timeout_q  <= 1'b0;
        end else begin
            div_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.s_valid) begin
                        s_ready_q    <= 1'b0;
                        sign_n_q     <= bus.s_num[WIDTH-1];
                        sign_d_q     <= bus.s_den[WIDTH-1];
                        div_num_q    <= magnitude(bus.s_num);
                        div_den_q    <= magnitude(bus.s_den);
                        m_err_div0_q <= 1'b0;
                        m_ovf_q      <= 1'b0;
                        m_timeout_q  <= 1'b0;
                        if (bus.s_den == '0) begin
                            m_quot_q     <= '0;
                            m_rem_q      <= bus.s_num;
                            m_err_div0_q <= 1'b1;
                            m_valid_q    <= 1'b1;
                            state_q      <= StOut;
                        end else begin
                            div_valid_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.div_ready) begin
                        m_quot_q  <= quot_fix;
                        m_rem_q   <= rem_fix;
                        m_ovf_q   <= ovf_fix;
                        m_valid_q <= 1'b1;
                        state_q   <= StOut;
                    end else if (timer_q == TimerLast) begin
                        m_quot_q    <= '0;
                        m_rem_q     <= '0;
                        m_timeout_q <= 1'b1;
                        m_valid_q   <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StOut: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.div_num    = div_num_q;
    assign bus.div_den    = div_den_q;
    assign bus.div_valid  = div_valid_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_quot     = m_quot_q;
    assign bus.m_rem      = m_rem_q;
    assign bus.m_err_div0 = m_err_div0_q;
    assign bus.m_ovf      = m_ovf_q;
    assign bus.m_timeout  = m_timeout_q;

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Bench for signed_div_sequencer: behavioural core, scoreboard of expected results,
// latency, stall, timeout and mid-operation reset scenarios.
module tb_signed_div_sequencer;

    localparam int W       = 12;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [2:0]   f;  // {err_div0, ovf, timeout}
    } exp_t;

    logic aclk;
    logic resetn;
    int   n_tests;
    int   n_fail;
    bit   core_mute;
    int   core_cnt;
    exp_t sb[$];

    signed_div_sequencer_if #(.WIDTH(W)) bus ();

    signed_div_sequencer #(
        .WIDTH  (W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk  (aclk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, need finished)");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core model answers 2*W+3 cycles after the div_valid cycle.
    always @(posedge aclk) begin
        if (!resetn) begin
            core_cnt      <= 0;
            bus.div_ready <= 1'b0;
            bus.div_quot  <= '0;
            bus.div_rem   <= '0;
        end else begin
            bus.div_ready <= 1'b0;
            if (bus.div_valid && !core_mute) begin
                core_cnt <= 2 * W + 2;
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    bus.div_ready <= 1'b1;
                    bus.div_quot  <= bus.div_num / bus.div_den;
                    bus.div_rem   <= bus.div_num % bus.div_den;
                end
            end
        end
    end

    always @(negedge aclk) begin
        exp_t e;
        if (resetn && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_result", {31'd0, bus.m_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("m_quot", {20'd0, bus.m_quot}, {20'd0, e.q});
                check_eq("m_rem", {20'd0, bus.m_rem}, {20'd0, e.r});
                check_eq("m_flags", {29'd0, bus.m_err_div0, bus.m_ovf, bus.m_timeout},
                         {29'd0, e.f});
            end
        end
    end

    function automatic exp_t model(input int num, input int den);
        exp_t e;
        int   q;
        int   r;
        e = '0;
        if (den == 0) begin
            e.r = num[W-1:0];
            e.f = 3'b100;
        end else begin
            q = num / den;
            r = num % den;
            if (q > 2047) begin
                q   = 2047;
                e.f = 3'b010;
            end
            e.q = q[W-1:0];
            e.r = r[W-1:0];
        end
        return e;
    endfunction

    // Called just after a negedge; returns at the negedge where m_valid is first seen.
    task automatic do_req(input int num, input int den, input exp_t e, output int lat);
        int waitc;
        int anum;
        int aden;
        anum = (num < 0) ? -num : num;
        aden = (den < 0) ? -den : den;
        sb.push_back(e);
        bus.s_valid = 1'b1;
        bus.s_num   = num[W-1:0];
        bus.s_den   = den[W-1:0];
        waitc = 0;
        while (!bus.s_ready && waitc < 100) begin
            @(negedge aclk);
            waitc++;
        end
        check_eq("s_ready_bound", waitc, 0);
        @(posedge aclk);
        #1 bus.s_valid = 1'b0;
        @(negedge aclk);
        lat = 1;
        if (den != 0) begin
            check_eq("div_valid_pulse", {31'd0, bus.div_valid}, 32'd1);
            check_eq("div_num", {20'd0, bus.div_num}, anum & 32'hFFF);
            check_eq("div_den", {20'd0, bus.div_den}, aden & 32'hFFF);
        end else begin
            check_eq("div0_no_pulse", {31'd0, bus.div_valid}, 32'd0);
        end
        while (!bus.m_valid && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        check_eq("m_valid_bound", {31'd0, bus.m_valid}, 32'd1);
    endtask

    task automatic after_accept();
        @(negedge aclk);
        check_eq("s_ready_after", {31'd0, bus.s_ready}, 32'd1);
        check_eq("m_valid_after", {31'd0, bus.m_valid}, 32'd0);
    endtask

    int   lat;
    int   bad;
    int   rn;
    int   rd;
    logic [2*W+2:0] snap;

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        core_mute   = 1'b0;
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_num   = '0;
        bus.s_den   = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 resetn = 1'b1;
        @(negedge aclk);
        check_eq("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check_eq("rst_div_valid", {31'd0, bus.div_valid}, 32'd0);
        check_eq("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        check_eq("rst_m_data", {8'd0, bus.m_quot, bus.m_rem}, 32'd0);
        check_eq("rst_m_flags", {29'd0, bus.m_err_div0, bus.m_ovf, bus.m_timeout}, 32'd0);

        do_req(100, 7, model(100, 7), lat);
        check_eq("nominal_latency", lat, 2 * W + 5);
        after_accept();
        do_req(-100, 7, model(-100, 7), lat);
        after_accept();
        do_req(100, -7, model(100, -7), lat);
        after_accept();
        do_req(-2048, -1, model(-2048, -1), lat);
        after_accept();
        do_req(-2048, 1, model(-2048, 1), lat);
        after_accept();
        do_req(55, 0, model(55, 0), lat);
        check_eq("div0_latency_le2", {31'd0, lat <= 2}, 32'd1);
        after_accept();
        do_req(-7, 100, model(-7, 100), lat);
        after_accept();
        for (int i = 0; i < 6; i++) begin
            rn = int'($urandom_range(0, 4095)) - 2048;
            rd = int'($urandom_range(0, 4095)) - 2048;
            do_req(rn, rd, model(rn, rd), lat);
            after_accept();
        end

        core_mute = 1'b1;
        do_req(321, 5, exp_t'({12'd0, 12'd0, 3'b001}), lat);
        check_eq("timeout_latency", lat, TIMEOUT + 1);
        after_accept();
        core_mute = 1'b0;

        bus.m_ready = 1'b0;
        do_req(1000, -33, model(1000, -33), lat);
        snap = {bus.m_quot, bus.m_rem, bus.m_err_div0, bus.m_ovf, bus.m_timeout};
        bad = 0;
        repeat (20) begin
            @(negedge aclk);
            if ({bus.m_quot, bus.m_rem, bus.m_err_div0, bus.m_ovf, bus.m_timeout} != snap ||
                bus.s_ready || !bus.m_valid) begin
                bad++;
            end
        end
        check_eq("stall_stable", bad, 0);
        bus.m_ready = 1'b1;
        @(negedge aclk);
        after_accept();

        bus.s_valid = 1'b1;
        bus.s_num   = 12'd300;
        bus.s_den   = 12'd9;
        @(posedge aclk);
        #1 bus.s_valid = 1'b0;
        repeat (5) @(negedge aclk);
        check_eq("wait_s_ready", {31'd0, bus.s_ready}, 32'd0);
        resetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        check_eq("mid_rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
        check_eq("mid_rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        resetn = 1'b1;
        repeat (40) @(negedge aclk);
        check_eq("post_rst_idle", {30'd0, bus.m_valid, bus.s_ready}, 32'd1);

        do_req(200, -9, model(200, -9), lat);
        after_accept();
        check_eq("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
